// File: rtl/fir_acc_mc.sv
// Multi-channel saturating FIR tap accumulator with automatic dump after TAPS
// addends, scaled/saturated output narrowing and a valid/ready result register.
module fir_acc_mc #(
  parameter int IN_W  = 21,
  parameter int ACC_W = 24,
  parameter int OUT_W = 21,
  parameter int N_CH  = 2,
  parameter int TAPS  = 16,
  parameter int SHIFT = 0,
  localparam int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk_b,
  input  logic                    rst_n,
  input  logic                    acc_en,
  input  logic                    acc_clr,
  input  logic [CHW-1:0]          acc_ch,
  input  logic signed [IN_W-1:0]  suma_wynik,
  input  logic                    wynik_ready,
  output logic signed [OUT_W-1:0] FIR_probka_wynik,
  output logic [CHW-1:0]          wynik_ch,
  output logic                    wynik_valid,
  output logic                    wynik_sat,
  output logic [N_CH-1:0]         ovf,
  output logic                    lost
);
  localparam int CNTW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc [N_CH];
  logic [CNTW-1:0]         cnt [N_CH];

  logic [N_CH-1:0]         hit;
  logic signed [ACC_W-1:0] acc_sel;
  logic [CNTW-1:0]         cnt_sel;
  logic signed [ACC_W:0]   sum_wide;
  logic signed [ACC_W-1:0] sum_clip;
  logic signed [ACC_W-1:0] sum_shr;
  logic [ACC_W-OUT_W:0]    upper;
  logic                    acc_ovf;
  logic                    out_clip;
  logic signed [OUT_W-1:0] out_val;
  logic                    is_last;
  logic                    do_add;
  logic                    dump;
  logic                    load;
  logic                    xfer;

  // Decoded select; channel codes >= N_CH match nothing and are thereby ignored.
  always_comb begin
    hit     = '0;
    acc_sel = '0;
    cnt_sel = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      hit[c] = (acc_ch == CHW'(c));
      if (hit[c]) begin
        acc_sel = acc[c];
        cnt_sel = cnt[c];
      end
    end
  end

  always_comb begin
    sum_wide = {acc_sel[ACC_W-1], acc_sel} + (ACC_W+1)'(suma_wynik);
    acc_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (acc_ovf) sum_clip = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    else         sum_clip = sum_wide[ACC_W-1:0];
    sum_shr  = sum_clip >>> SHIFT;
    // Fits in OUT_W only when all bits above the output sign bit match it.
    upper    = sum_shr[ACC_W-1:OUT_W-1];
    out_clip = ~((&upper) | ~(|upper));
    if (out_clip) out_val = sum_shr[ACC_W-1] ? OUT_MIN : OUT_MAX;
    else          out_val = sum_shr[OUT_W-1:0];
    is_last  = (cnt_sel == LAST);
    do_add   = acc_en & ~acc_clr & (|hit);
    dump     = do_add & is_last;
    xfer     = wynik_valid & wynik_ready;
    load     = dump & (~wynik_valid | wynik_ready);
  end

  always_ff @(posedge clk_b) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end
      ovf              <= '0;
      lost             <= 1'b0;
      wynik_valid      <= 1'b0;
      wynik_sat        <= 1'b0;
      wynik_ch         <= '0;
      FIR_probka_wynik <= '0;
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (hit[c] && acc_clr) begin
          acc[c] <= '0;
          cnt[c] <= '0;
          ovf[c] <= 1'b0;
        end else if (hit[c] && acc_en) begin
          if (acc_ovf) ovf[c] <= 1'b1;
          if (is_last) begin
            acc[c] <= '0;
            cnt[c] <= '0;
          end else begin
            acc[c] <= sum_clip;
            cnt[c] <= cnt_sel + CNTW'(1);
          end
        end
      end

      if (load) begin
        FIR_probka_wynik <= out_val;
        wynik_ch         <= acc_ch;
        wynik_sat        <= out_clip;
        wynik_valid      <= 1'b1;
      end else if (xfer) begin
        wynik_valid      <= 1'b0;
      end

      if (dump && !load) lost <= 1'b1;
    end
  end
endmodule

// File: doc/fir_acc_mc.md
# fir_acc_mc

Parametrised multi-channel accumulator for the FIR datapath. It sits after the tap multiplier/adder (`suma_wynik`) and keeps one running sum per channel. Each sum is saturated to `ACC_W` bits. When a channel has received `TAPS` contributions, its sum is dumped automatically, scaled and saturated to `OUT_W` bits, and presented on a valid/ready output. The accumulator is then re-armed for the next sample. It replaces the single-channel, hold-only accumulator with true add, per-channel state, overflow handling and output back-pressure.

## Interface
- `IN_W`, 21, signed width of the `suma_wynik` addend
- `ACC_W`, 24, signed width of each channel accumulator (must be ≥ `IN_W`)
- `OUT_W`, 21, signed width of `FIR_probka_wynik` (must be ≤ `ACC_W`)
- `N_CH`, 2, number of channels (≥ 1); `CHW` = max(1, clog2(`N_CH`))
- `TAPS`, 16, number of addends per output sample (≥ 1)
- `SHIFT`, 0, arithmetic right shift applied before output narrowing (0 ≤ `SHIFT` < `ACC_W`)

Ports:
- `clk_b` in 1: single clock; all logic on rising edge
- `rst_n` in 1: synchronous, active-low reset
- `acc_en` in 1: add `suma_wynik` to the accumulator of channel `acc_ch`
- `acc_clr` in 1: clear the accumulator, tap count and `ovf` of channel `acc_ch`
- `acc_ch` in `CHW`: channel select for `acc_en`/`acc_clr`; values ≥ `N_CH` are ignored (no effect)
- `suma_wynik` in `IN_W`: signed addend
- `wynik_ready` in 1: downstream accepts the output beat
- `FIR_probka_wynik` out `OUT_W`: signed result sample
- `wynik_ch` out `CHW`: channel of the result
- `wynik_valid` out 1: result held and valid
- `wynik_sat` out 1: result was clipped during output narrowing
- `ovf` out `N_CH`: per-channel sticky accumulator-saturation flag
- `lost` out 1: sticky flag; a dump was discarded because the output was occupied

## Operation
- Per channel c, the block holds `acc[c]` (signed `ACC_W`) and `cnt[c]` (0..`TAPS`-1).
- Add, on `acc_en` for channel c:
  - s = `acc[c]` + sign-extended `suma_wynik`, computed at `ACC_W`+1 bits.
  - s is clipped to [-2^(`ACC_W`-1), 2^(`ACC_W`-1)-1]. If clipping occurs, `ovf[c]` is set to 1.
- Not final (`cnt[c]` < `TAPS`-1): `acc[c]` ← clipped s; `cnt[c]` ← `cnt[c]`+1.
- Final (`cnt[c]` = `TAPS`-1): this is a dump.
  - `acc[c]` ← 0 and `cnt[c]` ← 0 unconditionally.
  - Output value = (clipped s >>> `SHIFT`), floor rounding, then clipped to the `OUT_W` signed range. `wynik_sat` = 1 if this output clip occurs.
- Dump acceptance: the dump is loaded if `wynik_valid` = 0, or if `wynik_valid` & `wynik_ready` in the same cycle. Loading sets `FIR_probka_wynik`, `wynik_ch` = c, `wynik_sat` and `wynik_valid` = 1.
- Dump discard: otherwise the dump is dropped, the held beat is unchanged, and `lost` ← 1.
- Output handshake: a beat transfers when `wynik_valid` & `wynik_ready`. If no dump loads in that cycle, `wynik_valid` ← 0. Output data stays stable while `wynik_valid` = 1 and `wynik_ready` = 0.
- Clear: `acc_clr` for channel c sets `acc[c]` ← 0, `cnt[c]` ← 0 and `ovf[c]` ← 0.
  - `acc_clr` has priority over `acc_en` in the same cycle: the addend is discarded and no dump occurs.
  - `acc_clr` does not affect an output beat already held.
- Flag clearing: `ovf` is cleared only by `acc_clr` or reset. `lost` is cleared only by reset.
- `TAPS` = 1: every `acc_en` is a dump.

## Timing
- Reset (`rst_n` = 0 at a rising edge) sets all `acc`, `cnt`, `ovf`, `lost`, `wynik_valid`, `wynik_sat`, `wynik_ch` and `FIR_probka_wynik` to 0. Reset mid-sample abandons all partial sums and any held beat.
- Add latency: 1 cycle. The updated `acc[c]` is visible to the next `acc_en` on the same channel, so back-to-back adds on one channel are supported every cycle.
- Dump latency: `wynik_valid` rises on the edge after the cycle carrying the final `acc_en`. That is, the output appears 1 cycle after the `TAPS`-th addend.
- Throughput: one dump per cycle is sustained when `wynik_ready` = 1.
- Output flags: `ovf` and `lost` update on the same edge as the event that sets them.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
Unless noted, parameters are `N_CH`=2, `TAPS`=4, `IN_W`=21, `ACC_W`=24, `OUT_W`=21, `SHIFT`=0, with `wynik_ready`=1.

1. Reset check: hold `rst_n`=0 during activity, then release. Required: all outputs read 0; the first post-reset sample on ch0 of 1,2,3,4 gives `FIR_probka_wynik`=10, `wynik_ch`=0, and `wynik_valid` high for exactly 1 cycle, one cycle after the 4th add.
2. Interleaved channels: ch0 gets 5,-3,7,1 and ch1 gets 100,200,300,400, alternating every cycle. Required: result 10 on ch0, then 1000 on ch1 on the following cycle.
3. Saturation: use `ACC_W`=22 and add 1048575 three times on ch0. Required: the accumulator clips at 2097151 and `ovf[0]`=1. Then, with `ACC_W`=24, feed 4×1048575. Required: `FIR_probka_wynik`=1048575 and `wynik_sat`=1.
4. Shift: use `SHIFT`=2 and add -1,-1,-1,-2 on ch0. Required: output -2 (floor of -5/4).
5. Back-pressure: hold `wynik_ready`=0 and complete ch0 (sum 10), then ch1 (sum 20). Required: the output holds 10/ch0 and `lost`=1. After `wynik_ready`=1 for 1 cycle, `wynik_valid`=0.
6. Clear priority: assert `acc_clr` with `acc_en` on ch0 at the 4th addend. Required: no dump, `cnt[0]`=0 and `ovf[0]`=0. The next four adds of 1 give 4.
